// File: rtl/prog_lut.sv
`default_nettype none
// ============================================================================
//  Module   : prog_lut
//  Purpose  : Programmable lookup table of DEPTH words of W bits.  Every entry
//             has a fixed default value which it takes at reset and which a
//             restore sequence rewrites one entry per clock.  One read port
//             and one write port are available each cycle.  Writes take
//             priority over reads of the same entry in the same cycle.
//
//  Ports    : Clk      - sole clock, all state changes on its rising edge
//             Reset    - synchronous active-high reset
//             RdEn     - read request, sampled each rising edge
//             RdAddr   - read address
//             RdData   - registered read data, held while no read occurs
//             RdValid  - one-cycle pulse, RdData carries a read result
//             RdErr    - one-cycle pulse with RdValid, address out of range
//             WrEn     - write request
//             WrAddr   - write address
//             WrData   - write data
//             WrErr    - one-cycle pulse, the previous cycle's write was
//                        rejected (address out of range, Busy or Restore)
//             Restore  - start reloading every entry with its default
//             Busy     - high while the restore sequence runs
//
//  Revision : 1.0  initial release
// ============================================================================
module prog_lut #(
    parameter int W     = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          RdEn,
    input  logic [AW-1:0] RdAddr,
    output logic [W-1:0]  RdData,
    output logic          RdValid,
    output logic          RdErr,
    input  logic          WrEn,
    input  logic [AW-1:0] WrAddr,
    input  logic [W-1:0]  WrData,
    output logic          WrErr,
    input  logic          Restore,
    output logic          Busy
);

    // Width of an in-range entry index.  DEPTH <= 2**AW guarantees IW <= AW.
    localparam int              IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     C_DEPTH = DEPTH;
    localparam logic [IW-1:0]   C_LAST = IW'(DEPTH - 1);

    // ------------------------------------------------------------------------
    // Default contents.  Values are defined as 32-bit numbers and then
    // zero-extended or truncated to the entry width.
    // ------------------------------------------------------------------------
    function automatic logic [W-1:0] f_default(input int unsigned idx);
        logic [31:0] v;
        case (idx)
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = 32'd4;
            3:       v = 32'd61;
            4:       v = 32'd62;
            5:       v = 32'd63;
            6:       v = 32'd32;
            7:       v = 32'd64;
            8:       v = 32'd255;
            9:       v = 32'd51;
            10:      v = 32'd59;
            11:      v = 32'd41;
            12:      v = 32'd22;
            default: v = 32'd0;
        endcase
        return W'(v);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nxt;
    logic [W-1:0]    r_mem [DEPTH];

    logic            w_restoring;
    logic            w_rd_in_range;
    logic            w_wr_in_range;
    logic            w_wr_ok;
    logic [IW-1:0]   w_rd_idx;
    logic [IW-1:0]   w_wr_idx;
    logic [W-1:0]    w_rd_word;

    assign w_restoring   = (r_state == RESTORE);
    assign w_rd_in_range = (32'(RdAddr) < C_DEPTH);
    assign w_wr_in_range = (32'(WrAddr) < C_DEPTH);
    assign w_rd_idx      = RdAddr[IW-1:0];
    assign w_wr_idx      = WrAddr[IW-1:0];

    // A user write is refused while restoring and also in the very cycle a
    // restore is requested, so a restore never races a user write.
    assign w_wr_ok = WrEn && w_wr_in_range && !w_restoring && !Restore;

    // Busy is the decoded state flop; it has no input-to-output path.
    assign Busy = w_restoring;

    // ------------------------------------------------------------------------
    // Restore sequencer: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (Restore) begin
                    w_state_nxt = RESTORE;
                    w_idx_nxt   = '0;
                end
            end
            RESTORE: begin
                // Restore requests are ignored here; the sequence runs to the
                // last entry and the index stops there instead of wrapping.
                if (r_idx == C_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Restore sequencer: state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Table storage.  User writes and restore writes never coincide because
    // user writes are refused while restoring.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= f_default(32'(i));
            end
        end else begin
            if (w_wr_ok) begin
                r_mem[w_wr_idx] <= WrData;
            end
            if (w_restoring) begin
                r_mem[r_idx] <= f_default(32'(r_idx));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path.  The returned word is the entry's content after this edge:
    // a same-cycle user write or restore write to the same entry is
    // forwarded in place of the stored value.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        if (w_wr_ok && (WrAddr == RdAddr)) begin
            w_rd_word = WrData;
        end else if (w_restoring && (r_idx == w_rd_idx)) begin
            w_rd_word = f_default(32'(r_idx));
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            RdData  <= '0;
            RdValid <= 1'b0;
            RdErr   <= 1'b0;
            WrErr   <= 1'b0;
        end else begin
            RdValid <= RdEn;
            RdErr   <= RdEn && !w_rd_in_range;
            WrErr   <= WrEn && !w_wr_ok;
            if (RdEn) begin
                RdData <= w_rd_in_range ? w_rd_word : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_lut.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_lut
//  Purpose  : Self-checking bench for prog_lut.  Two instances share all
//             inputs: one with DEPTH=16 and one with DEPTH=13.  A table of
//             read vectors, hand-written restore/reset sequences and a
//             randomized phase are compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_lut;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset, RdEn, WrEn, Restore;
    logic [3:0]  RdAddr, WrAddr;
    logic [15:0] WrData;

    logic [15:0] rdd0, rdd1;
    logic        rv0, rv1, re0, re1, we0, we1, bz0, bz1;

    int checks = 0;
    int errors = 0;

    prog_lut #(.W(16), .AW(4), .DEPTH(16)) dut0 (
        .Clk(Clk), .Reset(Reset), .RdEn(RdEn), .RdAddr(RdAddr),
        .RdData(rdd0), .RdValid(rv0), .RdErr(re0),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrErr(we0),
        .Restore(Restore), .Busy(bz0)
    );

    prog_lut #(.W(16), .AW(4), .DEPTH(13)) dut1 (
        .Clk(Clk), .Reset(Reset), .RdEn(RdEn), .RdAddr(RdAddr),
        .RdData(rdd1), .RdValid(rv1), .RdErr(re1),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrErr(we1),
        .Restore(Restore), .Busy(bz1)
    );

    // ------------------------------------------------------------------------
    // Behavioural model: per instance an array of entries, the position of an
    // ongoing restore (-1 when none) and the expected registered outputs.
    // ------------------------------------------------------------------------
    int          dep[2]  = '{16, 13};
    int          defs[13] = '{0, 1, 4, 61, 62, 63, 32, 64, 255, 51, 59, 41, 22};
    logic [15:0] mm[2][16];
    int          rpos[2];
    logic [15:0] e_data[2];
    bit          e_valid[2], e_err[2], e_wrerr[2], e_busy[2];

    function automatic int defv(int i);
        return (i < 13) ? defs[i] : 0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(int k, bit rst, bit rden, logic [3:0] ra,
                              bit wren, logic [3:0] wa, logic [15:0] wd, bit rs);
        int d;
        bit busy_now, wr_ok;
        d = dep[k];
        if (rst) begin
            for (int i = 0; i < 16; i++) mm[k][i] = 16'(defv(i));
            rpos[k]    = -1;
            e_data[k]  = '0;
            e_valid[k] = 1'b0;
            e_err[k]   = 1'b0;
            e_wrerr[k] = 1'b0;
        end else begin
            busy_now = (rpos[k] >= 0);
            wr_ok    = wren && (int'(wa) < d) && !busy_now && !rs;
            if (wr_ok) mm[k][wa] = wd;
            if (busy_now) begin
                mm[k][rpos[k]] = 16'(defv(rpos[k]));
                rpos[k]++;
                if (rpos[k] == d) rpos[k] = -1;
            end else if (rs) begin
                rpos[k] = 0;
            end
            e_wrerr[k] = wren && !wr_ok;
            e_valid[k] = rden;
            e_err[k]   = rden && (int'(ra) >= d);
            if (rden) e_data[k] = (int'(ra) < d) ? mm[k][ra] : 16'h0;
        end
        e_busy[k] = (rpos[k] >= 0);
    endtask

    task automatic cmp(int k, logic [15:0] d, logic v, logic e, logic we, logic b);
        chk($sformatf("dut%0d.rddata", k),  32'(d),  32'(e_data[k]));
        chk($sformatf("dut%0d.rdvalid", k), 32'(v),  32'(e_valid[k]));
        chk($sformatf("dut%0d.rderr", k),   32'(e),  32'(e_err[k]));
        chk($sformatf("dut%0d.wrerr", k),   32'(we), 32'(e_wrerr[k]));
        chk($sformatf("dut%0d.busy", k),    32'(b),  32'(e_busy[k]));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then compare.
    task automatic step(bit rst, bit rden, logic [3:0] ra, bit wren,
                        logic [3:0] wa, logic [15:0] wd, bit rs);
        Reset = rst; RdEn = rden; RdAddr = ra;
        WrEn = wren; WrAddr = wa; WrData = wd; Restore = rs;
        @(posedge Clk);
        model_edge(0, rst, rden, ra, wren, wa, wd, rs);
        model_edge(1, rst, rden, ra, wren, wa, wd, rs);
        #1;
        cmp(0, rdd0, rv0, re0, we0, bz0);
        cmp(1, rdd1, rv1, re1, we1, bz1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0);
    endtask

    task automatic rd(logic [3:0] a);
        step(1'b0, 1'b1, a, 1'b0, 4'd0, 16'h0, 1'b0);
    endtask

    // Table vectors for the DEPTH=16 instance
    typedef struct {
        bit          rst;
        bit          rden;
        logic [3:0]  ra;
        bit          exp_valid;
        bit          exp_err;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl[$];
    int   exp_tab[16] = '{0, 1, 4, 61, 62, 63, 32, 64, 255, 51, 59, 41, 22, 0, 0, 0};

    initial begin
        int cnt;

        Reset = 1'b1; RdEn = 1'b0; RdAddr = '0;
        WrEn = 1'b0; WrAddr = '0; WrData = '0; Restore = 1'b0;

        // Reset with a simultaneous read: read discarded, outputs cleared.
        tbl.push_back('{1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 16'h0});
        for (int i = 0; i < 16; i++)
            tbl.push_back('{1'b0, 1'b1, 4'(i), 1'b1, 1'b0, 16'(exp_tab[i])});
        tbl.push_back('{1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 16'd255});
        // No read: valid drops and data holds the last value.
        tbl.push_back('{1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 16'd255});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].rden, tbl[i].ra, 1'b0, 4'd0, 16'h0, 1'b0);
            chk($sformatf("tbl%0d.valid", i), 32'(rv0),  32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d.err", i),   32'(re0),  32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d.data", i),  32'(rdd0), 32'(tbl[i].exp_data));
        end

        // Same-cycle write and read of one address: write-first.
        step(1'b0, 1'b1, 4'd3, 1'b1, 4'd3, 16'hBEEF, 1'b0);
        chk("wf.same_cycle", 32'(rdd0), 32'hBEEF);
        rd(4'd3);
        chk("wf.next_read", 32'(rdd0), 32'hBEEF);

        // Out-of-range read and write on the DEPTH=13 instance.
        rd(4'd14);
        chk("d13.rd14.data", 32'(rdd1), 32'h0);
        chk("d13.rd14.valid", 32'(rv1), 32'h1);
        chk("d13.rd14.err", 32'(re1), 32'h1);
        step(1'b0, 1'b0, 4'd0, 1'b1, 4'd13, 16'hDEAD, 1'b0);
        chk("d13.wr13.wrerr", 32'(we1), 32'h1);
        chk("d16.wr13.wrerr", 32'(we0), 32'h0);
        rd(4'd12);
        chk("d13.rd12.data", 32'(rdd1), 32'd22);

        // Restore length, write rejection while busy, ignored re-restore.
        step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 16'h1234, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 4'd8, 16'h1234, 1'b0);
        rd(4'd8);
        chk("rs.pre8", 32'(rdd0), 32'h1234);
        step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b1);
        chk("rs.busy_start", 32'(bz0), 32'h1);
        cnt = bz0 ? 1 : 0;
        step(1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 16'h5555, 1'b0);
        chk("rs.wr_busy.wrerr", 32'(we0), 32'h1);
        cnt += bz0 ? 1 : 0;
        for (int n = 0; n < 40 && bz0; n++) begin
            step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0, n == 6);
            cnt += bz0 ? 1 : 0;
        end
        chk("rs.busy_len", 32'(cnt), 32'd16);
        rd(4'd0);
        chk("rs.addr0", 32'(rdd0), 32'd0);
        rd(4'd8);
        chk("rs.addr8", 32'(rdd0), 32'd255);

        // Reset on the fifth busy cycle ends the restore at once.
        step(1'b0, 1'b0, 4'd0, 1'b1, 4'd10, 16'h7777, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b1);
        for (int n = 0; n < 4; n++) idle();
        chk("rr.busy5", 32'(bz0), 32'h1);
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0);
        chk("rr.busy_off", 32'(bz0), 32'h0);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
            chk($sformatf("rr.def%0d", i), 32'(rdd0), 32'(exp_tab[i]));
        end

        // Restore and write in the same idle cycle: write refused.
        step(1'b0, 1'b0, 4'd0, 1'b1, 4'd2, 16'hAAAA, 1'b1);
        chk("rw.wrerr", 32'(we0), 32'h1);
        chk("rw.busy", 32'(bz0), 32'h1);
        for (int n = 0; n < 40 && bz0; n++) idle();
        chk("rw.done", 32'(bz0), 32'h0);
        rd(4'd2);
        chk("rw.addr2", 32'(rdd0), 32'd4);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            logic [3:0] ra, wa;
            ra = 4'($urandom_range(0, 15));
            wa = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            step($urandom_range(0, 99) == 0, 1'($urandom), ra,
                 1'($urandom), wa, 16'($urandom), $urandom_range(0, 24) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
